// File: rtl/button_reader_pkg.sv
// Shared definitions for the PMOD push-button reader.
//   btn_state_e           : per-button debounce FSM state encoding
//   DEBOUNCE_CYCLES_12MHZ : default stable-sample count (10 ms at 12 MHz)
package button_reader_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam int unsigned DEBOUNCE_CYCLES_12MHZ = 120000;

endpackage : button_reader_pkg

// File: rtl/debounce_fsm.sv
// One-button synchronizer + debouncer.
//   clk    : system clock
//   rst_n  : active-low reset (async assert, released synchronously by the parent)
//   pin    : raw button, active-low, asynchronous, bouncy
//   level  : debounced state, 1 = pressed (registered)
//   press  : 1-cycle pulse on each accepted release->pressed transition (registered)
// DEBOUNCE_CYCLES must be >= 2.
module debounce_fsm
    import button_reader_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_12MHZ
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic press
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]    sync_q, sync_d;
    btn_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          s;

    // Synchronized and inverted: 1 = pressed.
    assign s = ~sync_q[1];

    always_comb begin
        sync_d  = {sync_q[0], pin};
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        unique case (state_q)
            ST_RELEASED: begin
                if (s) begin
                    // The sample that leaves RELEASED already counts as the first
                    // stable one, so the qualifying run is exactly DEBOUNCE_CYCLES
                    // samples and the pin-to-level latency is 2+DEBOUNCE_CYCLES.
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_PRESS_WAIT: begin
                if (!s) begin
                    state_d = ST_RELEASED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_PRESSED;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (!s) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_RELEASE_WAIT: begin
                if (s) begin
                    // Release bounce: back to PRESSED without a new press pulse.
                    state_d = ST_PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_RELEASED;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_RELEASED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            state_q <= ST_RELEASED;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule : debounce_fsm

// File: rtl/button_reader.sv
// PMOD push-button reader: debounced levels, press pulses and a press counter.
//   clk       : system clock (12 MHz)
//   rst_btn   : active-low reset, async assert, synchronously released
//   pmod      : raw buttons, active-low, asynchronous, bouncy
//   btn_level : debounced state per button, 1 = pressed
//   btn_press : 1-cycle pulse per accepted press
//   led       : press counter (btn 0 increments, btn 1 clears, clear wins)
module button_reader
    import button_reader_pkg::*;
#(
    parameter int unsigned NUM_BTNS        = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_12MHZ,
    parameter int unsigned CNT_WIDTH       = 3
) (
    input  logic                 clk,
    input  logic                 rst_btn,
    input  logic [NUM_BTNS-1:0]  pmod,
    output logic [NUM_BTNS-1:0]  btn_level,
    output logic [NUM_BTNS-1:0]  btn_press,
    output logic [CNT_WIDTH-1:0] led
);

    logic [1:0]           rst_sync_q, rst_sync_d;
    logic                 rst_n;
    logic [CNT_WIDTH-1:0] led_q, led_d;

    // Reset asserts immediately but is released two clocks after rst_btn rises.
    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_n      = rst_sync_q[1];

    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        debounce_fsm #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .rst_n (rst_n),
            .pin   (pmod[i]),
            .level (btn_level[i]),
            .press (btn_press[i])
        );
    end

    always_comb begin
        led_d = led_q;
        if (btn_press[1]) begin
            led_d = '0;
        end else if (btn_press[0]) begin
            led_d = led_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    assign led = led_q;

endmodule : button_reader
